// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner.
// Holds the digit count, the BCD payload layout, the active-high segment
// patterns ({g,f,e,d,c,b,a}) and the digit-index encoding.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned BCD_W      = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

    // Packed BCD word as delivered by the binary-to-BCD stage.
    typedef struct packed {
        logic [NIBBLE_W-1:0] hundreds;
        logic [NIBBLE_W-1:0] tens;
        logic [NIBBLE_W-1:0] ones;
    } bcd_t;

    // Which digit owns the current slot; also the scan order.
    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } dig_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to seven-segment pattern decoder (combinational, active-high).
// Ports:
//   nibble  in   4-bit BCD digit
//   seg_c   out  pattern {g..a}; non-decimal nibbles A-F show a dash
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (nibble)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 3-digit common-anode seven-segment driver.
// Scans ones, tens, hundreds in turn, each slot starting with a dark
// anti-ghosting interval. The BCD value and dp requests are captured once
// per frame so a frame never mixes old and new digits.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bcd         packed BCD {hundreds, tens, ones}
//   dp_in       decimal-point request per digit (bit0 = ones)
//   blank_lz    blank leading zeros (sampled live)
//   seg, dp     registered segment / decimal-point drive
//   an          registered anode enables (an[0] = ones)
//   frame_tick  one-cycle pulse after each snapshot
module bcd_seg7_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BCD_W-1:0]      bcd,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      div_cnt_nxt;
    dig_idx_t              dig_idx;
    dig_idx_t              dig_idx_nxt;
    bcd_t                  snap_bcd;
    logic [NUM_DIGITS-1:0] snap_dp;

    logic                  wrap_c;
    logic                  snap_c;
    logic [NIBBLE_W-1:0]   nibble_c;
    logic                  dp_req_c;
    logic [NUM_DIGITS-1:0] an_sel_c;
    logic                  suppress_c;
    logic                  lit_c;
    logic [SEG_W-1:0]      pattern_c;
    logic [SEG_W-1:0]      seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign wrap_c = (div_cnt == CNT_W'(REFRESH_DIV - 1));
    assign snap_c = (div_cnt == '0) && (dig_idx == DIG_ONES);

    // Slot counter and snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            dig_idx  <= DIG_ONES;
            snap_bcd <= '0;
            snap_dp  <= '0;
        end else begin
            div_cnt <= div_cnt_nxt;
            dig_idx <= dig_idx_nxt;
            if (snap_c) begin
                snap_bcd <= bcd_t'(bcd);
                snap_dp  <= dp_in;
            end
        end
    end

    // Next slot position: advance the digit on counter wrap.
    always_comb begin
        div_cnt_nxt = div_cnt + CNT_W'(1);
        dig_idx_nxt = dig_idx;
        if (wrap_c) begin
            div_cnt_nxt = '0;
            case (dig_idx)
                DIG_ONES: dig_idx_nxt = DIG_TENS;
                DIG_TENS: dig_idx_nxt = DIG_HUNDREDS;
                default:  dig_idx_nxt = DIG_ONES;
            endcase
        end
    end

    // Select the active digit and work out leading-zero suppression.
    always_comb begin
        nibble_c   = snap_bcd.ones;
        dp_req_c   = snap_dp[0];
        an_sel_c   = 3'b001;
        suppress_c = 1'b0;
        case (dig_idx)
            DIG_TENS: begin
                nibble_c   = snap_bcd.tens;
                dp_req_c   = snap_dp[1];
                an_sel_c   = 3'b010;
                suppress_c = blank_lz && (snap_bcd.hundreds == 4'd0)
                                      && (snap_bcd.tens == 4'd0);
            end
            DIG_HUNDREDS: begin
                nibble_c   = snap_bcd.hundreds;
                dp_req_c   = snap_dp[2];
                an_sel_c   = 3'b100;
                suppress_c = blank_lz && (snap_bcd.hundreds == 4'd0);
            end
            default: ;
        endcase
    end

    seg7_decode u_decode (
        .nibble (nibble_c),
        .seg_c  (pattern_c)
    );

    // Lit only after the dark interval and when not suppressed; polarity last.
    always_comb begin
        lit_c   = (div_cnt >= CNT_W'(BLANK_CYCLES)) && !suppress_c;
        seg_nxt = (lit_c ? pattern_c : '0) ^ SEG_OFF;
        dp_nxt  = (lit_c && dp_req_c) ^ DP_OFF;
        an_nxt  = (lit_c ? an_sel_c : '0) ^ AN_OFF;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            frame_tick <= snap_c;
        end
    end

endmodule
